// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the IF/ID boundary.
// Contents: XLEN/ILEN/NOP_INSTR widths and constants, fetch_pkt_t payload,
// ifid_state_t buffer state encoding, nop_pkt() helper.
package pipeline_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned CNT_W = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_pkt_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_HALF,
    S_FULL
  } ifid_state_t;

  // Packet shown to decode when nothing is held: pc 0, addi x0,x0,0.
  function automatic fetch_pkt_t nop_pkt();
    fetch_pkt_t p;
    p.pc    = '0;
    p.instr = NOP_INSTR;
    return p;
  endfunction

endpackage

// File: rtl/if_id_buffer.sv
// IF/ID boundary: 2-entry skid buffer between fetch and decode.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   flush_i                synchronous flush (taken branch/jump), highest priority
//   in_valid/in_ready      fetch handshake, in_pc/in_instr payload
//   out_valid/out_ready    decode handshake, out_pc/out_instr payload
//   bubble_cnt             present only when IFID_BUBBLE_CNT_EN is defined:
//                          saturating count of cycles decode was ready but starved
// in_ready/out_valid come straight from flops, so there is no
// out_ready -> in_ready combinational path.
module if_id_buffer
  import pipeline_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [ILEN-1:0]  in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [ILEN-1:0]  out_instr
`ifdef IFID_BUBBLE_CNT_EN
  ,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  ifid_state_t state_q, state_d;
  fetch_pkt_t  main_q, main_d;
  fetch_pkt_t  skid_q, skid_d;
  fetch_pkt_t  in_pkt;
  logic        in_fire, out_fire;

  assign in_pkt.pc    = in_pc;
  assign in_pkt.instr = in_instr;

  // Next-state and next-payload logic.
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready;

    if (flush_i) begin
      state_d = S_EMPTY;
      main_d  = nop_pkt();
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d = S_HALF;
            main_d  = in_pkt;
          end
        end
        S_HALF: begin
          if (in_fire && out_fire) begin
            main_d = in_pkt;
          end else if (in_fire) begin
            state_d = S_FULL;
            skid_d  = in_pkt;
          end else if (out_fire) begin
            // Going empty: park the NOP so decode never sees stale data.
            state_d = S_EMPTY;
            main_d  = nop_pkt();
          end
        end
        S_FULL: begin
          if (out_fire) begin
            state_d = S_HALF;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_d  = nop_pkt();
        end
      endcase
    end
  end

  // State, payload and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      main_q    <= nop_pkt();
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      in_ready  <= (state_d != S_FULL);
      out_valid <= (state_d != S_EMPTY);
    end
  end

  assign out_pc    = main_q.pc;
  assign out_instr = main_q.instr;

`ifdef IFID_BUBBLE_CNT_EN
  // Saturating starvation counter; flush does not touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (out_ready && !out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer with a queue-based reference model
// checked on every falling clock edge, plus literal spot checks.
module tb_if_id_buffer;
  import pipeline_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush_i = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_pc = '0;
  logic [ILEN-1:0] in_instr = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_instr;
`ifdef IFID_BUBBLE_CNT_EN
  logic [31:0]     bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  if_id_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr)
`ifdef IFID_BUBBLE_CNT_EN
    ,
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the buffer is a FIFO of depth 2.
  fetch_pkt_t q[$];
  logic [31:0] m_bubbles = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_bubbles = '0;
    end else begin
      bit acc, pop;
      fetch_pkt_t p;
      acc = in_valid && (q.size() < 2);
      pop = out_ready && (q.size() > 0);
      if (out_ready && (q.size() == 0) && (m_bubbles != 32'hFFFF_FFFF))
        m_bubbles = m_bubbles + 32'd1;
      if (flush_i) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) begin
          p.pc = in_pc;
          p.instr = in_instr;
          q.push_back(p);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model away from the active edge.
  always @(negedge clk) begin
    chk("m_out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("m_in_ready",  64'(in_ready),  64'(q.size() < 2));
    chk("m_out_pc",    out_pc,         (q.size() > 0) ? q[0].pc : 64'h0);
    chk("m_out_instr", 64'(out_instr), 64'((q.size() > 0) ? q[0].instr : NOP_INSTR));
`ifdef IFID_BUBBLE_CNT_EN
    chk("m_bubble_cnt", 64'(bubble_cnt), 64'(m_bubbles));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] pc, input logic [31:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit %0d", 100000);
    $fatal(1);
  end

  initial begin
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 2. Streaming at full throughput.
    out_ready = 1'b1;
    send(64'h1000, 32'h0050_0093); tick();
    chk("s_pc0", out_pc, 64'h1000);
    chk("s_in0", 64'(out_instr), 64'h0050_0093);
    send(64'h1004, 32'h0060_0113); tick();
    chk("s_pc1", out_pc, 64'h1004);
    chk("s_rdy1", 64'(in_ready), 64'd1);
    send(64'h1008, 32'h0070_0193); tick();
    chk("s_pc2", out_pc, 64'h1008);
    in_valid = 1'b0; tick();
    chk("s_empty", 64'(out_valid), 64'd0);
    chk("s_nop", 64'(out_instr), 64'(NOP_INSTR));

    // 3. Backpressure fills the skid slot.
    out_ready = 1'b0;
    send(64'h2000, 32'h0000_1111); tick();
    chk("b_rdy0", 64'(in_ready), 64'd1);
    send(64'h2004, 32'h0000_2222); tick();
    chk("b_full", 64'(in_ready), 64'd0);
    send(64'h2008, 32'h0000_3333); tick(); tick();
    chk("b_stable", out_pc, 64'h2000);
    chk("b_held", 64'(in_ready), 64'd0);
    out_ready = 1'b1; tick();
    chk("b_pc1", out_pc, 64'h2004);
    tick();
    chk("b_pc2", out_pc, 64'h2008);
    in_valid = 1'b0; tick();
    chk("b_drain", 64'(out_valid), 64'd0);

    // 4. Flush while full with a packet on the input.
    out_ready = 1'b0;
    send(64'h3100, 32'h0000_4444); tick();
    send(64'h3104, 32'h0000_5555); tick();
    send(64'h3000, 32'h0000_6666);
    flush_i = 1'b1; tick();
    flush_i = 1'b0; in_valid = 1'b0;
    chk("f_valid", 64'(out_valid), 64'd0);
    chk("f_nop", 64'(out_instr), 64'(NOP_INSTR));
    chk("f_pc", out_pc, 64'h0);
    out_ready = 1'b1; tick(); tick();
    chk("f_gone", 64'(out_valid), 64'd0);

    // 5. Simultaneous accept and consume in the half state.
    send(64'h4000, 32'h0000_7777); tick();
    send(64'h4004, 32'h0000_8888); tick();
    chk("h_pc", out_pc, 64'h4004);
    chk("h_rdy", 64'(in_ready), 64'd1);
    in_valid = 1'b0; tick();

    // 1. Reset mid-stream.
    out_ready = 1'b0;
    send(64'h5000, 32'h0000_9999); tick();
    send(64'h5004, 32'h0000_aaaa); tick();
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("r_valid", 64'(out_valid), 64'd0);
    chk("r_rdy", 64'(in_ready), 64'd1);
    chk("r_instr", 64'(out_instr), 64'h13);
    chk("r_pc", out_pc, 64'h0);
    rst_n = 1'b1;
    tick();

`ifdef IFID_BUBBLE_CNT_EN
    // 6. Starvation counter: 10 ready cycles, 3 stalled, then a flush.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("c_cnt", 64'(bubble_cnt), 64'd10);
    flush_i = 1'b1; tick();
    flush_i = 1'b0;
    chk("c_flush", 64'(bubble_cnt), 64'd10);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
